// File: rtl/cpu_result_checker_if.sv
// Read-side bus between the result checker and the register file, data memory and expected-value ROM.
// With CHECK_MASK_EN defined the ROM also supplies a per-bit compare mask aligned with exp_data.
interface cpu_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
);
  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [IDX_W-1:0]  dm_raddr;
  logic [DATA_W-1:0] dm_rdata;
  logic [IDX_W-1:0]  exp_addr;
  logic [DATA_W-1:0] exp_data;
`ifdef CHECK_MASK_EN
  logic [DATA_W-1:0] exp_mask;

  modport master (
    output rf_raddr, dm_raddr, exp_addr,
    input  rf_rdata, dm_rdata, exp_data, exp_mask
  );
  modport slave (
    input  rf_raddr, dm_raddr, exp_addr,
    output rf_rdata, dm_rdata, exp_data, exp_mask
  );
`else
  modport master (
    output rf_raddr, dm_raddr, exp_addr,
    input  rf_rdata, dm_rdata, exp_data
  );
  modport slave (
    input  rf_raddr, dm_raddr, exp_addr,
    output rf_rdata, dm_rdata, exp_data
  );
`endif
endinterface

// File: rtl/cpu_result_checker.sv
// Self-check sequencer: resets and runs the CPU for a fixed budget, then scans regs and dmem against a ROM.
// Optional CHECK_MASK_EN: compare only the bits set in bus.exp_mask.
module cpu_result_checker #(
  parameter int RESET_CYCLES = 10,
  parameter int RUN_CYCLES   = 40,
  parameter int NUM_REGS     = 32,
  parameter int NUM_WORDS    = 128,
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 8,
  parameter int FAIL_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  cpu_result_checker_if.master bus,
  output logic                 o_cpu_rst,
  output logic                 o_cpu_ce,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [FAIL_W-1:0]    o_fail_cnt,
  output logic                 o_first_vld,
  output logic [IDX_W-1:0]     o_first_idx,
  output logic [DATA_W-1:0]    o_first_got,
  output logic [DATA_W-1:0]    o_first_exp
);

  // state    | meaning
  // IDLE/HOLD| CPU in reset (HOLD also clocks it) | RUN: CPU free-running
  // SCAN_*   | issue read indices | DRAIN: last compare | DONE: results valid, CPU frozen
  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_SCAN_REG, S_SCAN_MEM, S_DRAIN, S_DONE
  } state_t;

  localparam int CNT_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS + NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] MEM_BASE = IDX_W'(NUM_REGS);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_cmp_vld;
  logic                r_cmp_mem;
  logic [IDX_W-1:0]    r_cmp_idx;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic                r_any_fail;
  logic                r_first_vld;
  logic [IDX_W-1:0]    r_first_idx;
  logic [DATA_W-1:0]   r_first_got;
  logic [DATA_W-1:0]   r_first_exp;
  logic                w_start_ok;
  logic                w_tc;
  logic [DATA_W-1:0]   w_got;
  logic [DATA_W-1:0]   w_diff;
  logic                w_mismatch;

  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_tc       = (r_cnt == '0);
  assign w_got      = r_cmp_mem ? bus.dm_rdata : bus.rf_rdata;
`ifdef CHECK_MASK_EN
  assign w_diff     = (w_got ^ bus.exp_data) & bus.exp_mask;
`else
  assign w_diff     = w_got ^ bus.exp_data;
`endif
  assign w_mismatch = r_cmp_vld && (|w_diff);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_next = S_HOLD;
      S_HOLD:         if (w_tc) w_next = S_RUN;
      S_RUN:          if (w_tc) w_next = S_SCAN_REG;
      S_SCAN_REG:     if (r_idx == LAST_REG) w_next = S_SCAN_MEM;
      S_SCAN_MEM:     if (r_idx == LAST_IDX) w_next = S_DRAIN;
      S_DRAIN:        w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_cpu_rst    = 1'b0;
    o_cpu_ce     = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    bus.rf_raddr = '0;
    bus.dm_raddr = '0;
    bus.exp_addr = '0;
    case (r_state)
      S_IDLE: o_cpu_rst = 1'b1;
      S_HOLD: begin
        o_cpu_rst = 1'b1;
        o_cpu_ce  = 1'b1;
        o_busy    = 1'b1;
      end
      S_RUN: begin
        o_cpu_ce = 1'b1;
        o_busy   = 1'b1;
      end
      S_SCAN_REG: begin
        o_busy       = 1'b1;
        bus.rf_raddr = r_idx;
        bus.exp_addr = r_idx;
      end
      S_SCAN_MEM: begin
        o_busy       = 1'b1;
        bus.dm_raddr = r_idx - MEM_BASE;
        bus.exp_addr = r_idx;
      end
      S_DRAIN: o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: o_cpu_rst = 1'b1;
    endcase
    o_pass = (r_state == S_DONE) && !r_any_fail;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_mem   <= 1'b0;
      r_cmp_idx   <= '0;
      r_fail_cnt  <= '0;
      r_any_fail  <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else begin
      r_cmp_vld <= (r_state == S_SCAN_REG) || (r_state == S_SCAN_MEM);
      r_cmp_mem <= (r_state == S_SCAN_MEM);
      r_cmp_idx <= r_idx;

      if (w_start_ok) begin
        r_cnt <= CNT_W'(RESET_CYCLES - 1);
        r_idx <= '0;
      end else if ((r_state == S_HOLD) && w_tc) begin
        r_cnt <= CNT_W'(RUN_CYCLES - 1);
      end else if (((r_state == S_HOLD) || (r_state == S_RUN)) && !w_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end else if ((r_state == S_SCAN_REG) || (r_state == S_SCAN_MEM)) begin
        r_idx <= r_idx + 1'b1;
      end

      // compares never overlap a start: the pipeline is empty in IDLE/DONE
      if (w_start_ok) begin
        r_fail_cnt  <= '0;
        r_any_fail  <= 1'b0;
        r_first_vld <= 1'b0;
        r_first_idx <= '0;
        r_first_got <= '0;
        r_first_exp <= '0;
      end else if (w_mismatch) begin
        r_any_fail <= 1'b1;
        if (r_fail_cnt != {FAIL_W{1'b1}}) r_fail_cnt <= r_fail_cnt + 1'b1;
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_cmp_idx;
          r_first_got <= w_got;
          r_first_exp <= bus.exp_data;
        end
      end
    end
  end

  assign o_fail_cnt  = r_fail_cnt;
  assign o_first_vld = r_first_vld;
  assign o_first_idx = r_first_idx;
  assign o_first_got = r_first_got;
  assign o_first_exp = r_first_exp;

endmodule

// File: tb/tb_cpu_result_checker.sv
// Directed bench for cpu_result_checker: a default-size instance plus a small FAIL_W=2 instance.
module tb_cpu_result_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start2;
  logic [31:0] mask;

  logic [31:0] rf_mem  [32];
  logic [31:0] dm_mem  [128];
  logic [31:0] exp_mem [160];
  logic [31:0] exp2_mem[8];

  logic        cpu_rst, cpu_ce, busy, done, pass, first_vld;
  logic [7:0]  fail_cnt, first_idx;
  logic [31:0] first_got, first_exp;

  logic        cpu_rst2, cpu_ce2, busy2, done2, pass2, first_vld2;
  logic [1:0]  fail_cnt2;
  logic [7:0]  first_idx2;
  logic [31:0] first_got2, first_exp2;

  int n_checks = 0;
  int n_errors = 0;

  cpu_result_checker_if #(.DATA_W(32), .IDX_W(8)) bus  ();
  cpu_result_checker_if #(.DATA_W(32), .IDX_W(8)) bus2 ();

  always #5 clk = ~clk;

  cpu_result_checker u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .bus(bus.master),
    .o_cpu_rst(cpu_rst), .o_cpu_ce(cpu_ce), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_fail_cnt(fail_cnt), .o_first_vld(first_vld), .o_first_idx(first_idx),
    .o_first_got(first_got), .o_first_exp(first_exp)
  );

  cpu_result_checker #(
    .RESET_CYCLES(2), .RUN_CYCLES(3), .NUM_REGS(4), .NUM_WORDS(4), .FAIL_W(2)
  ) u_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start2), .bus(bus2.master),
    .o_cpu_rst(cpu_rst2), .o_cpu_ce(cpu_ce2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_fail_cnt(fail_cnt2), .o_first_vld(first_vld2), .o_first_idx(first_idx2),
    .o_first_got(first_got2), .o_first_exp(first_exp2)
  );

`ifdef CHECK_MASK_EN
  assign bus.exp_mask  = mask;
  assign bus2.exp_mask = 32'hFFFF_FFFF;
`endif

  always @(posedge clk) begin
    bus.rf_rdata  <= rf_mem[bus.rf_raddr[4:0]];
    bus.dm_rdata  <= dm_mem[bus.dm_raddr[6:0]];
    bus.exp_data  <= (bus.exp_addr < 8'd160) ? exp_mem[bus.exp_addr] : 32'h0;
    bus2.rf_rdata <= 32'hC0DE_0000 + 32'(bus2.rf_raddr);
    bus2.dm_rdata <= 32'hBEEF_0000 + 32'(bus2.dm_raddr);
    bus2.exp_data <= exp2_mem[bus2.exp_addr[2:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pulses start, then samples every negedge until done; optionally pulses start again mid-RUN.
  task automatic run_dut(input bit poke_run, output int n_rst, output int n_ce,
                         output int gap, output bit seen);
    int  t_fall;
    bit  prev_ce;
    n_rst = 0; n_ce = 0; gap = -1; seen = 1'b0; t_fall = -1; prev_ce = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (cpu_rst) n_rst++;
      if (cpu_ce)  n_ce++;
      if (prev_ce && !cpu_ce) t_fall = c;
      prev_ce = cpu_ce;
      if (done) begin
        seen = 1'b1;
        gap  = c - t_fall;
      end else begin
        start = (poke_run && n_ce == 25) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int  n_rst, n_ce, gap;
    bit  seen;

    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
      exp_mem[i] = rf_mem[i];
    end
    for (int k = 0; k < 128; k++) begin
      dm_mem[k]       = 32'hA5A5_0000 ^ (32'(k) * 32'd7);
      exp_mem[32 + k] = dm_mem[k];
    end
    for (int i = 0; i < 4; i++) begin
      exp2_mem[i]     = 32'hC0DE_0000 + 32'(i);
      exp2_mem[4 + i] = 32'hBEEF_0000 + 32'(i);
    end
    exp2_mem[1] ^= 32'h1;
    exp2_mem[2] ^= 32'h2;
    exp2_mem[4] ^= 32'h4;
    exp2_mem[6] ^= 32'h8;
    exp2_mem[7] ^= 32'h10;
    mask   = 32'hFFFF_FFFF;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_first_vld", first_vld, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst", cpu_rst, 1);

    // all expected values match
    run_dut(1'b0, n_rst, n_ce, gap, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_pass", pass, 1);
    chk("t1_fail_cnt", fail_cnt, 0);
    chk("t1_first_vld", first_vld, 0);
    chk("t1_ce_cycles", n_ce, 50);
    chk("t1_scan_gap", gap, 161);
    chk("t1_busy", busy, 0);
    chk("t1_frozen_rst", cpu_rst, 0);
    chk("t1_frozen_ce", cpu_ce, 0);

    // rerun straight from DONE, with a stray start during RUN
    run_dut(1'b1, n_rst, n_ce, gap, seen);
    chk("t3_done_seen", seen, 1);
    chk("t3_rst_cycles", n_rst, 10);
    chk("t3_ce_cycles", n_ce, 50);
    chk("t3_scan_gap", gap, 161);
    chk("t3_pass", pass, 1);
    repeat (3) @(negedge clk);
    chk("t3_done_holds", done, 1);

    // two mismatches: register 5 and dmem word 7
    exp_mem[5]  ^= 32'h0000_0001;
    exp_mem[39] ^= 32'h8000_0000;
    run_dut(1'b0, n_rst, n_ce, gap, seen);
    chk("t2_done_seen", seen, 1);
    chk("t2_pass", pass, 0);
    chk("t2_fail_cnt", fail_cnt, 2);
    chk("t2_first_vld", first_vld, 1);
    chk("t2_first_idx", first_idx, 5);
    chk("t2_first_got", first_got, rf_mem[5]);
    chk("t2_first_exp", first_exp, exp_mem[5]);

    // reset while scanning dmem, then a clean rerun
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (bus.exp_addr >= 8'd40) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t5_reached_mem", seen, 1);
    chk("t5_mid_fail_cnt", fail_cnt, 1);
    chk("t5_mid_first_vld", first_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_cpu_rst", cpu_rst, 1);
    chk("t5_abort_cpu_ce", cpu_ce, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_first_vld", first_vld, 0);
    chk("t5_abort_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_dut(1'b0, n_rst, n_ce, gap, seen);
    chk("t5_done_seen", seen, 1);
    chk("t5_scan_gap", gap, 161);
    chk("t5_fail_cnt", fail_cnt, 2);
    chk("t5_first_idx", first_idx, 5);

    // saturation on the small instance: five mismatches into a 2-bit counter
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen   = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done2) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t4_done_seen", seen, 1);
    chk("t4_fail_cnt_sat", fail_cnt2, 3);
    chk("t4_pass", pass2, 0);
    chk("t4_first_idx", first_idx2, 1);
    chk("t4_first_got", first_got2, 32'hC0DE_0001);
    chk("t4_first_exp", first_exp2, 32'hC0DE_0000);

`ifdef CHECK_MASK_EN
    exp_mem[5]  = rf_mem[5];
    exp_mem[39] = dm_mem[7];
    exp_mem[10] = rf_mem[10] ^ 32'h0000_00FF;
    mask = 32'hFFFF_0000;
    run_dut(1'b0, n_rst, n_ce, gap, seen);
    chk("t6_masked_done", seen, 1);
    chk("t6_masked_pass", pass, 1);
    chk("t6_masked_fail_cnt", fail_cnt, 0);
    mask = 32'hFFFF_FFFF;
    run_dut(1'b0, n_rst, n_ce, gap, seen);
    chk("t6_full_done", seen, 1);
    chk("t6_full_pass", pass, 0);
    chk("t6_full_fail_cnt", fail_cnt, 1);
    chk("t6_full_first_idx", first_idx, 10);
    chk("t6_full_first_got", first_got, rf_mem[10]);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
